// File: rtl/piso_serializer_if.sv
// Load port and serial output bundle of the parallel-in serial-out transmitter.
// A word transfers on a rising edge where load_valid and load_ready are both 1. The sender
// holds load_data stable while load_valid is high and not yet accepted.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             sdata;
  logic             sframe;
  logic             slast;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  sdata,
    input  sframe,
    input  slast
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output sdata,
    output sframe,
    output slast
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one bit per enabled clock on sdata with frame/last
// markers. en freezes every register, matching the enable of the downstream capture flops.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  piso_serializer_if.slave  bus,
  output logic              state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] NEXT_LAST = CW'(WIDTH - 2);
  localparam int OUT_POS = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             sframe_q;
  logic             slast_q;
  logic             accept;

  // Moves the next bit into the output position; vacated positions fill with 0.
  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  // slast_q is exactly "SHIFT with count at its final value", so it doubles as the
  // back-to-back reload window.
  assign bus.load_ready = rst_n & en & ((state == IDLE) | slast_q);
  assign accept         = bus.load_valid & bus.load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      count    <= '0;
      sframe_q <= 1'b0;
      slast_q  <= 1'b0;
    end else if (en) begin
      if (accept) begin
        state    <= SHIFT;
        shreg    <= bus.load_data;
        count    <= '0;
        sframe_q <= 1'b1;
        slast_q  <= 1'b0;
      end else if (state == SHIFT) begin
        if (slast_q) begin
          // Clearing shreg keeps sdata a plain register bit that reads 0 in IDLE.
          state    <= IDLE;
          shreg    <= '0;
          count    <= '0;
          sframe_q <= 1'b0;
          slast_q  <= 1'b0;
        end else begin
          shreg    <= shifted(shreg);
          count    <= count + CW'(1);
          slast_q  <= (count == NEXT_LAST);
        end
      end
    end
  end

  assign bus.sdata  = shreg[OUT_POS];
  assign bus.sframe = sframe_q;
  assign bus.slast  = slast_q;
  assign state_dbg  = (state == SHIFT);

endmodule
